// File: rtl/id_ex_stage.sv
// ID/EX pipeline register built as a two-entry skid buffer.
// The main register drives Out_* directly; the skid register catches the one
// bundle that can arrive while the execute stage stalls. In_Ready depends only
// on the state register, so there is no combinational path from Out_Ready.
// Optional build macro: ID_EX_STALL_CNT_EN adds a saturating 16-bit
// Stall_Count output (cycles with Out_Valid=1 and Out_Ready=0, cleared by reset only).
//
// state | meaning
// EMPTY | nothing held, Out_Valid=0, In_Ready=1
// BUSY  | main register holds a bundle, skid empty
// FULL  | main and skid registers both hold bundles, In_Ready=0
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Flush,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [XLEN-1:0] In_Rs1_Data,
    input  logic [XLEN-1:0] In_Rs2_Data,
    input  logic [XLEN-1:0] In_Imm,
    input  logic            In_Alu_Src,
    input  logic [3:0]      In_Alu_Op,
    input  logic [4:0]      In_Rd,
    input  logic            In_Reg_Write,
    input  logic            In_Mem_Write,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [XLEN-1:0] Out_Rs1_Data,
    output logic [XLEN-1:0] Out_Rs2_Data,
    output logic [XLEN-1:0] Out_Imm,
    output logic            Out_Alu_Src,
    output logic [3:0]      Out_Alu_Op,
    output logic [4:0]      Out_Rd,
    output logic            Out_Reg_Write,
    output logic            Out_Mem_Write
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]     Stall_Count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic [3:0]      alu_op;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
    } bundle_t;

    state_t  state, state_nxt;
    bundle_t main_q, skid_q, in_bundle;
    logic    fire_in, fire_out;
    logic    load_main_in, load_main_skid, load_skid, drain_main;

    assign in_bundle = '{rs1: In_Rs1_Data, rs2: In_Rs2_Data, imm: In_Imm,
                         alu_src: In_Alu_Src, alu_op: In_Alu_Op, rd: In_Rd,
                         reg_write: In_Reg_Write, mem_write: In_Mem_Write};

    assign In_Ready  = (state == EMPTY) || (state == BUSY);
    assign Out_Valid = (state == BUSY) || (state == FULL);
    assign fire_in   = In_Valid && In_Ready;
    assign fire_out  = Out_Valid && Out_Ready;

    // State register; reset and flush both return to EMPTY.
    always_ff @(posedge Clk) begin
        if (!Rst_n || Flush) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and register load controls.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        drain_main     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (fire_in) begin
                    state_nxt    = BUSY;
                    load_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (fire_in && fire_out) begin
                    load_main_in = 1'b1;
                end else if (fire_in) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (fire_out) begin
                    state_nxt  = EMPTY;
                    drain_main = 1'b1;
                end
            end
            FULL: begin
                if (fire_out) begin
                    state_nxt      = BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Main and skid registers; write enables drop whenever the stage empties.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (Flush) begin
            main_q.reg_write <= 1'b0;
            main_q.mem_write <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_q <= in_bundle;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end else if (drain_main) begin
                main_q.reg_write <= 1'b0;
                main_q.mem_write <= 1'b0;
            end
            if (load_skid) begin
                skid_q <= in_bundle;
            end
        end
    end

    assign Out_Rs1_Data  = main_q.rs1;
    assign Out_Rs2_Data  = main_q.rs2;
    assign Out_Imm       = main_q.imm;
    assign Out_Alu_Src   = main_q.alu_src;
    assign Out_Alu_Op    = main_q.alu_op;
    assign Out_Rd        = main_q.rd;
    assign Out_Reg_Write = main_q.reg_write;
    assign Out_Mem_Write = main_q.mem_write;

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Saturating count of back-pressured cycles; flush leaves it untouched.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt <= '0;
        end else if (Out_Valid && !Out_Ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign Stall_Count = stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, single transfer, skid fill/drain,
// flush in FULL, 100-bundle stream under toggling back-pressure, reset in FULL,
// and (with ID_EX_STALL_CNT_EN) stall counter behaviour.
module tb_id_ex_stage;
    localparam int XLEN = 32;

    logic            Clk = 1'b0;
    logic            Rst_n, Flush, In_Valid, In_Ready;
    logic [XLEN-1:0] In_Rs1_Data, In_Rs2_Data, In_Imm;
    logic            In_Alu_Src;
    logic [3:0]      In_Alu_Op;
    logic [4:0]      In_Rd;
    logic            In_Reg_Write, In_Mem_Write;
    logic            Out_Valid, Out_Ready;
    logic [XLEN-1:0] Out_Rs1_Data, Out_Rs2_Data, Out_Imm;
    logic            Out_Alu_Src;
    logic [3:0]      Out_Alu_Op;
    logic [4:0]      Out_Rd;
    logic            Out_Reg_Write, Out_Mem_Write;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0]     Stall_Count;
`endif

    id_ex_stage #(.XLEN(XLEN)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Rs1_Data(In_Rs1_Data), .In_Rs2_Data(In_Rs2_Data), .In_Imm(In_Imm),
        .In_Alu_Src(In_Alu_Src), .In_Alu_Op(In_Alu_Op), .In_Rd(In_Rd),
        .In_Reg_Write(In_Reg_Write), .In_Mem_Write(In_Mem_Write),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Rs1_Data(Out_Rs1_Data), .Out_Rs2_Data(Out_Rs2_Data), .Out_Imm(Out_Imm),
        .Out_Alu_Src(Out_Alu_Src), .Out_Alu_Op(Out_Alu_Op), .Out_Rd(Out_Rd),
        .Out_Reg_Write(Out_Reg_Write), .Out_Mem_Write(Out_Mem_Write)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .Stall_Count(Stall_Count)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic alu_src, input logic rw);
        In_Valid     = v;
        In_Rd        = rd;
        In_Rs2_Data  = rs2;
        In_Rs1_Data  = rs2 ^ 32'hFFFF_0000;
        In_Imm       = imm;
        In_Alu_Src   = alu_src;
        In_Alu_Op    = rd[3:0];
        In_Reg_Write = rw;
        In_Mem_Write = rd[0];
    endtask

    initial begin
        int tx;
        int rx;
        logic rdy;

        Rst_n = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(); step();
        check("rst_out_valid", Out_Valid, 0);
        check("rst_in_ready", In_Ready, 1);
        check("rst_out_imm", Out_Imm, 0);
        check("rst_out_reg_write", Out_Reg_Write, 0);

        // single bundle, immediate operand selected
        Rst_n = 1'b1;
        Out_Ready = 1'b1;
        drive(1'b1, 5'd3, 32'h0000_0005, 32'h0000_0010, 1'b1, 1'b1);
        step();
        check("single_out_valid", Out_Valid, 1);
        check("single_out_imm", Out_Imm, 32'h10);
        check("single_out_alu_src", Out_Alu_Src, 1);
        check("single_out_rd", Out_Rd, 3);
        check("single_out_reg_write", Out_Reg_Write, 1);
        check("single_out_rs1", Out_Rs1_Data, 32'hFFFF_0005);
        In_Valid = 1'b0;
        step();
        check("drain_out_valid", Out_Valid, 0);
        check("drain_reg_write_clr", Out_Reg_Write, 0);
        check("drain_mem_write_clr", Out_Mem_Write, 0);

        // fill skid under back-pressure, then drain in order
        Out_Ready = 1'b0;
        drive(1'b1, 5'd1, 32'h0000_0111, 32'h0, 1'b0, 1'b1);
        step();
        check("fill1_in_ready", In_Ready, 1);
        check("fill1_out_rd", Out_Rd, 1);
        drive(1'b1, 5'd2, 32'h0000_0222, 32'h0, 1'b0, 1'b1);
        step();
        check("full_in_ready", In_Ready, 0);
        check("full_out_rd", Out_Rd, 1);
        drive(1'b1, 5'd9, 32'h0000_0999, 32'h0, 1'b0, 1'b1);
        step();
        check("full_hold_rd", Out_Rd, 1);
        check("full_hold_rs2", Out_Rs2_Data, 32'h111);
        check("full_hold_valid", Out_Valid, 1);
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        check("deliver1_rd", Out_Rd, 1);
        step();
        check("deliver2_valid", Out_Valid, 1);
        check("deliver2_rd", Out_Rd, 2);
        check("deliver2_rs2", Out_Rs2_Data, 32'h222);
        step();
        check("after_drain_valid", Out_Valid, 0);

        // flush while FULL with simultaneous output ready and input offer
        Out_Ready = 1'b0;
        drive(1'b1, 5'd4, 32'h0000_0444, 32'h0, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'd5, 32'h0000_0555, 32'h0, 1'b0, 1'b1);
        step();
        check("flush_pre_full", In_Ready, 0);
        Flush = 1'b1;
        Out_Ready = 1'b1;
        drive(1'b1, 5'd6, 32'h0000_0666, 32'h0, 1'b0, 1'b1);
        step();
        check("flush_out_valid", Out_Valid, 0);
        check("flush_reg_write", Out_Reg_Write, 0);
        check("flush_in_ready", In_Ready, 1);
        Flush = 1'b0;
        In_Valid = 1'b0;
        step();
        check("flush_no_deliver", Out_Valid, 0);

        // 100-bundle stream with Out_Ready toggling every cycle
        tx = 0;
        rx = 0;
        rdy = 1'b0;
        for (int c = 0; c < 600 && rx < 100; c++) begin
            rdy = ~rdy;
            Out_Ready = rdy;
            if (tx < 100)
                drive(1'b1, tx[4:0], 32'h1000_0000 + 32'(tx) * 32'd7, 32'h0, 1'b0, 1'b1);
            else
                In_Valid = 1'b0;
            if (Out_Valid && Out_Ready) begin
                check("stream_rs2", Out_Rs2_Data, 32'h1000_0000 + 32'(rx) * 32'd7);
                rx++;
            end
            if (In_Valid && In_Ready) tx++;
            step();
        end
        check("stream_count", 64'(rx), 100);
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        step();
        check("stream_empty", Out_Valid, 0);

`ifdef ID_EX_STALL_CNT_EN
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        check("stall_rst", Stall_Count, 0);
        Out_Ready = 1'b0;
        drive(1'b1, 5'd7, 32'h0000_0777, 32'h0, 1'b0, 1'b1);
        step();
        In_Valid = 1'b0;
        check("stall_first", Stall_Count, 0);
        step(); step(); step();
        check("stall_three", Stall_Count, 3);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("stall_flush_keep", Stall_Count, 4);
        step();
        check("stall_empty_hold", Stall_Count, 4);
        drive(1'b1, 5'd8, 32'h0000_0888, 32'h0, 1'b0, 1'b1);
        step();
        In_Valid = 1'b0;
        repeat (70000) @(posedge Clk);
        #1;
        check("stall_sat", Stall_Count, 16'hFFFF);
        step(); step(); step();
        check("stall_sat_hold", Stall_Count, 16'hFFFF);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
`endif

        // reset while FULL overrides flush and handshakes
        Out_Ready = 1'b0;
        drive(1'b1, 5'd10, 32'hABCD_0001, 32'h0000_00AA, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd11, 32'hABCD_0002, 32'h0000_00BB, 1'b1, 1'b1);
        step();
        check("rstfull_pre", In_Ready, 0);
        Rst_n = 1'b0;
        Flush = 1'b1;
        Out_Ready = 1'b1;
        drive(1'b1, 5'd12, 32'hABCD_0003, 32'h0000_00CC, 1'b1, 1'b1);
        step();
        check("rstfull_valid", Out_Valid, 0);
        check("rstfull_in_ready", In_Ready, 1);
        check("rstfull_rs1", Out_Rs1_Data, 0);
        check("rstfull_rs2", Out_Rs2_Data, 0);
        check("rstfull_imm", Out_Imm, 0);
        check("rstfull_ctl", {Out_Alu_Src, Out_Alu_Op, Out_Rd, Out_Reg_Write, Out_Mem_Write}, 0);
`ifdef ID_EX_STALL_CNT_EN
        check("rstfull_stall", Stall_Count, 0);
`endif
        Rst_n = 1'b1;
        Flush = 1'b0;
        In_Valid = 1'b0;
        step();
        check("rstfull_no_leak", Out_Valid, 0);
        check("rstfull_no_leak_rs2", Out_Rs2_Data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, datapath width of the Rs1, Rs2 and Imm fields.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port Clk  input  1  rising-edge clock for all state.
REQ-004 Port Rst_n  input  1  synchronous active-low reset.
REQ-005 Port Flush  input  1  discard all held entries (branch/jump redirect).
REQ-006 Port In_Valid  input  1  decode stage presents a valid instruction bundle.
REQ-007 Port In_Ready  output  1  stage can accept a bundle this cycle.
REQ-008 Port In_Rs1_Data, In_Rs2_Data, In_Imm  input  XLEN each  register operands and sign-extended immediate.
REQ-009 Port In_Alu_Src  input  1  0 = operand B is Rs2 data, 1 = operand B is the immediate.
REQ-010 Port In_Alu_Op  input  4  ALU operation code.
REQ-011 Port In_Rd  input  5  destination register index.
REQ-012 Port In_Reg_Write, In_Mem_Write  input  1 each  write-enable controls.
REQ-013 Port Out_Valid  output  1  bundle on Out_* is valid.
REQ-014 Port Out_Ready  input  1  execute stage accepts the bundle this cycle.
REQ-015 Ports Out_Rs1_Data, Out_Rs2_Data, Out_Imm, Out_Alu_Src, Out_Alu_Op, Out_Rd, Out_Reg_Write, Out_Mem_Write  output  registered copies of the In_* fields; Out_Rs2_Data, Out_Imm and Out_Alu_Src drive the ALU operand-B 2:1 mux inputs A, B and select.

Function
REQ-016 Input handshake SHALL fire when In_Valid & In_Ready; output handshake SHALL fire when Out_Valid & Out_Ready.
REQ-017 Storage SHALL be a two-entry skid buffer (main register driving Out_*, plus one skid register) with state machine EMPTY, BUSY (main held), FULL (main + skid held).
REQ-018 EMPTY: input fire -> BUSY, main <= In_*; otherwise stay.
REQ-019 BUSY: input fire and output fire -> BUSY, main <= In_*; input fire only -> FULL, skid <= In_*; output fire only -> EMPTY; neither -> stay.
REQ-020 FULL: output fire -> BUSY, main <= skid; otherwise stay; no input fire is possible.
REQ-021 Out_Valid SHALL be 1 exactly in BUSY or FULL; In_Ready SHALL be 1 exactly in EMPTY or BUSY, decoded from the state register only (no combinational path from Out_Ready or In_Valid).
REQ-022 Latency SHALL be one cycle: a bundle accepted at edge N appears on Out_* after edge N when the stage was EMPTY or drained that cycle.
REQ-023 Ordering SHALL be strict FIFO; no bundle is duplicated or dropped except by Flush or reset.
REQ-024 Out_* fields SHALL be held stable while Out_Valid=1 and Out_Ready=0.
REQ-025 Flush=1 at an edge SHALL force state EMPTY and clear Out_Reg_Write and Out_Mem_Write, taking priority over any simultaneous input or output fire; a bundle offered in that cycle is discarded.
REQ-026 When not Out_Valid, Out_Reg_Write and Out_Mem_Write SHALL be 0; data fields may retain old values.

Reset
REQ-027 At an edge with Rst_n=0: state EMPTY, all Out_* registers and the skid register cleared to 0, Out_Valid=0, In_Ready=1 from the following cycle.
REQ-028 Reset SHALL override Flush and all handshakes, including mid-transfer in FULL.

Configuration
REQ-029 Macro ID_EX_STALL_CNT_EN defined: the block SHALL add output Stall_Count (16 bits) counting cycles with Out_Valid=1 and Out_Ready=0, saturating at 16'hFFFF, cleared only by reset (not by Flush).
REQ-030 Macro ID_EX_STALL_CNT_EN undefined: port Stall_Count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset then In_Valid=1, Imm=32'h0000_0010, Alu_Src=1, Out_Ready=1 -> next cycle Out_Valid=1, Out_Imm=32'h10, Out_Alu_Src=1.
REQ-032 Out_Ready=0, push bundles Rd=1 then Rd=2 -> state FULL, In_Ready=0, Out_Rd=1 held; raise Out_Ready -> Rd=1 then Rd=2 delivered in consecutive cycles.
REQ-033 FULL with Flush=1 and Out_Ready=1 same edge -> next cycle Out_Valid=0, Out_Reg_Write=0, In_Ready=1, no bundle delivered.
REQ-034 Streaming 100 bundles with Out_Ready toggling every cycle -> all 100 delivered in order, Rs2_Data values matching input sequence.
REQ-035 Rst_n=0 asserted while FULL -> next cycle Out_Valid=0, all Out_* = 0; with ID_EX_STALL_CNT_EN, Stall_Count=0.
REQ-036 With ID_EX_STALL_CNT_EN, hold Out_Valid=1, Out_Ready=0 for 70000 cycles -> Stall_Count=16'hFFFF and stays there.
